// File: rtl/mode_encoder.sv
// mode_encoder: debounced push-button to one-hot recorder mode encoder.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_key_record/play/pause/stop   raw active-low keys, asynchronous
//   i_rec_done, i_play_done        synchronous 1-cycle done pulses
//   o_mode                         IDLE=000 RECORD=001 PLAY=010 PAUSE=100
//   o_new_session                  pulse on IDLE->RECORD / IDLE->PLAY
//   o_mode_changed                 pulse in the cycle o_mode takes a new value
//   o_resume_mode                  mode restored on leaving PAUSE, 000 elsewhere
module mode_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 20'd1000000,
  parameter int unsigned CNT_W = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_record,
  input  logic       i_key_play,
  input  logic       i_key_pause,
  input  logic       i_key_stop,
  input  logic       i_rec_done,
  input  logic       i_play_done,
  output logic [2:0] o_mode,
  output logic       o_new_session,
  output logic       o_mode_changed,
  output logic [2:0] o_resume_mode
);
  typedef enum logic [2:0] {IDLE = 3'b000, RECORD = 3'b001, PLAY = 3'b010, PAUSE = 3'b100} state_e;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // key bit order: 0 record, 1 play, 2 pause, 3 stop
  logic [3:0] keys, sync1_q, sync2_q, deb_q, deb_d, deb_prev_q, ev;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  state_e state_q, state_d;
  logic [2:0] resume_q, resume_d;
  logic new_session_q, mode_changed_q;
  assign keys = {i_key_stop, i_key_pause, i_key_play, i_key_record};
  // press event: debounced level fell on the previous edge
  assign ev = deb_prev_q & ~deb_q;
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = (sync2_q[i] == deb_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + CNT_W'(1);
      deb_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] == LAST) ? sync2_q[i] : deb_q[i];
    end
  end
  // per-state ternary chains encode done > stop > pause > record > play
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = ev[0] ? RECORD : ev[1] ? PLAY : IDLE;
      RECORD:  state_d = (i_rec_done || ev[3]) ? IDLE : ev[2] ? PAUSE : RECORD;
      PLAY:    state_d = (i_play_done || ev[3]) ? IDLE : ev[2] ? PAUSE : PLAY;
      PAUSE:   state_d = ev[3] ? IDLE :
                         (ev[2] || (resume_q == RECORD && ev[0]) || (resume_q == PLAY && ev[1])) ?
                         state_e'(resume_q) : PAUSE;
      default: state_d = IDLE;
    endcase
    // remember the mode we paused from; cleared whenever PAUSE is left
    resume_d = (state_d == PAUSE) ? ((state_q == PAUSE) ? resume_q : state_q) : 3'b000;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q        <= '1;
      sync2_q        <= '1;
      deb_q          <= '1;
      deb_prev_q     <= '1;
      cnt_q          <= '0;
      state_q        <= IDLE;
      resume_q       <= '0;
      new_session_q  <= 1'b0;
      mode_changed_q <= 1'b0;
    end else begin
      sync1_q        <= keys;
      sync2_q        <= sync1_q;
      deb_q          <= deb_d;
      deb_prev_q     <= deb_q;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      resume_q       <= resume_d;
      new_session_q  <= (state_q == IDLE) && (state_d != IDLE);
      mode_changed_q <= state_d != state_q;
    end
  end
  assign o_mode         = (state_q inside {IDLE, RECORD, PLAY, PAUSE}) ? state_q : IDLE;
  assign o_new_session  = new_session_q;
  assign o_mode_changed = mode_changed_q;
  assign o_resume_mode  = (state_q == PAUSE) ? resume_q : 3'b000;
endmodule

// File: doc/mode_encoder.md
Name: mode_encoder

Overview:
- Converts raw DE2-115 push-button presses into the 3-bit one-hot mode code for the lab3 audio recorder.
- The same code drives the mode digit display and the record/play datapath.
- Debounces and edge-detects each key, then runs the recorder mode state machine.
- Issues session and mode-change strobes to the address and audio controllers.

Parameters:
- DEBOUNCE_CYCLES, 20'd1000000, consecutive identical synchronized samples needed to accept a key level change (min 2).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_key_record  input  1  raw KEY, active-low, asynchronous to i_clk
- i_key_play  input  1  raw KEY, active-low, asynchronous
- i_key_pause  input  1  raw KEY, active-low, asynchronous
- i_key_stop  input  1  raw KEY, active-low, asynchronous
- i_rec_done  input  1  synchronous 1-cycle pulse: SRAM full
- i_play_done  input  1  synchronous 1-cycle pulse: playback reached end of recording
- o_mode  output  3  IDLE=3'b000, RECORD=3'b001, PLAY=3'b010, PAUSE=3'b100
- o_new_session  output  1  1-cycle pulse on IDLE->RECORD or IDLE->PLAY (address reset)
- o_mode_changed  output  1  1-cycle pulse whenever o_mode changes
- o_resume_mode  output  3  mode restored when leaving PAUSE (RECORD or PLAY); 3'b000 otherwise

Behaviour:
- Reset: the async assert forces all outputs to 0 immediately.
  - Synchronizer FFs and debounced levels go to 1 (released). Counters go to 0.
  - A reset mid-session abandons the session. After release, the block is in IDLE.
- Per key:
  - 2-FF synchronizer, then the debouncer.
  - The counter clears whenever the synchronized sample equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the sample still differs, the debounced level takes the sample and the counter clears.
  - A press event is a 1-cycle pulse on the debounced level 1->0. Release generates no event.
- Latency: key low sampled first at edge k, and held. The debounced level falls at edge k+1+DEBOUNCE_CYCLES. o_mode and the strobes update at edge k+2+DEBOUNCE_CYCLES.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES samples produces no event.
- Holding a key produces exactly one event.
- FSM transitions (event = press event; all others ignored):
  - IDLE: record -> RECORD; play -> PLAY. Both assert o_new_session. pause and stop are ignored.
  - RECORD: stop or i_rec_done -> IDLE. pause -> PAUSE with resume=RECORD. record and play are ignored.
  - PLAY: stop or i_play_done -> IDLE. pause -> PAUSE with resume=PLAY. record and play are ignored.
  - PAUSE:
    - pause -> resume mode.
    - The key matching the resume mode -> resume mode.
    - The other start key is ignored.
    - stop -> IDLE. Resume is cleared.
    - done pulses are ignored.
- Same-cycle priority: done pulse > stop > pause > record > play. Only the highest applicable event acts; the rest are dropped, not queued.
- Resume does not assert o_new_session.
- o_mode_changed asserts in the cycle o_mode takes its new value; it is the registered comparison of next vs current.
- o_resume_mode holds its value only while in PAUSE; 3'b000 in every other state.
- o_mode is always one of the four legal codes. An illegal state register value recovers to IDLE on the next clock.

Test Plan:
- Bench sets DEBOUNCE_CYCLES=4.
- Reset release, no keys -> o_mode=000, all strobes 0. Assert i_rst_n=0 while in PLAY -> outputs 0 with no clock edge.
- record key low from edge k, held 20 cycles -> at edge k+6: o_mode=001, o_new_session=1 and o_mode_changed=1 for 1 cycle only. Release -> no further change.
- In IDLE, play key low for 3 cycles then high (bounce) -> o_mode stays 000, no strobes.
- PLAY -> pause press -> o_mode=100, o_resume_mode=010. record press -> no change. play press -> o_mode=010, o_new_session=0, o_mode_changed=1.
- RECORD, i_rec_done pulse in the same cycle as a pause event -> o_mode=000. Pause is dropped and stays dropped afterward.
- PAUSE (resume=001), stop and pause events in the same cycle -> o_mode=000, o_resume_mode=000.
